// File: rtl/seq_divider.sv
// Iterative signed divider: restoring shift-subtract on operand magnitudes, one
// quotient bit per clock, with signs applied at the end to match Verilog "/" and "%".
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] result,
  output logic             V,
  output logic             Z,
  output logic             S,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;    // |dividend| shifting out, quotient bits shifting in
  logic [WIDTH-1:0] part;     // partial remainder; always < |divisor| so WIDTH bits suffice
  logic [WIDTH:0]   b_mag;
  logic [WIDTH-1:0] a_raw;
  logic             q_neg, r_neg, sel_q, dbz_q, ovf_q;

  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] q_fix, r_fix, res_fix;

  // The done cycle still counts as the tail of the previous operation.
  assign accept = start && !done;
  assign busy   = (state != IDLE);

  assign a_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign trial = {part, shreg[WIDTH-1]};
  assign fits  = (trial >= b_mag);

  assign q_fix   = dbz_q ? '1    : (q_neg ? -shreg : shreg);
  assign r_fix   = dbz_q ? a_raw : (r_neg ? -part  : part);
  assign res_fix = sel_q ? r_fix : q_fix;

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (divisor == '0) ? FIX : CALC;
      CALC:    if (count == CW'(1)) state_nx = FIX;
      FIX:     if (count == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      shreg     <= '0;
      part      <= '0;
      b_mag     <= '0;
      a_raw     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      sel_q     <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      result    <= '0;
      V         <= 1'b0;
      Z         <= 1'b0;
      S         <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sel_q <= sel_rem;
            a_raw <= dividend;
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
            ovf_q <= (dividend == MOST_NEG) && (divisor == '1);
            shreg <= a_abs;
            b_mag <= {1'b0, b_abs};
            part  <= '0;
            // Divide-by-zero idles one cycle in FIX so both paths share the output step.
            dbz_q <= (divisor == '0);
            count <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
          end
        end
        CALC: begin
          count <= count - CW'(1);
          shreg <= {shreg[WIDTH-2:0], fits};
          part  <= fits ? WIDTH'(trial - b_mag) : trial[WIDTH-1:0];
        end
        FIX: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
            result    <= res_fix;
            V         <= ovf_q;
            Z         <= (res_fix == '0);
            S         <= res_fix[WIDTH-1];
            dbz       <= dbz_q;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle signed divider that computes quotient and remainder with a start/busy/done handshake. It is the iterative counterpart to the single-cycle multiply path: the ALU's combinational divide and modulo are replaced by this unit. The control FSM stalls on busy and collects the result, V/Z/S flags and divide-by-zero status on done. Arithmetic semantics match the Verilog signed "/" and "%" operators exactly.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sel_rem  input  1  captured with start; 0: result = quotient, 1: result = remainder
dividend  input  WIDTH  signed operand a; captured with start
divisor  input  WIDTH  signed operand b; captured with start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when quotient/remainder/result/flags are valid
quotient  output  WIDTH  signed quotient
remainder  output  WIDTH  signed remainder
result  output  WIDTH  quotient or remainder per captured sel_rem
V  output  1  overflow (most-negative / -1)
Z  output  1  result == 0
S  output  1  result[WIDTH-1]
dbz  output  1  divisor was zero

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, V, Z, S, dbz = 0; quotient, remainder, result = 0; iteration counter = 0.
- States:
  - IDLE: on start=1, capture operands and sel_rem.
    - If divisor==0: go to FIX with the dbz path.
    - Otherwise: load |dividend|, |divisor|, partial remainder 0, counter=WIDTH; record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)); go to CALC.
  - CALC: one restoring shift-subtract step per clock, MSB first; decrement counter; when the counter reaches 0 after the step, go to FIX.
  - FIX: apply the recorded signs, register all outputs, pulse done=1, return to IDLE.
- busy = 1 while in CALC or FIX.
- Latency:
  - Normal case: start sampled at edge 0; done is high during the cycle after edge WIDTH+1 (33 edges for WIDTH=32).
  - dbz path: done after edge 2.
- Magnitude arithmetic is WIDTH+1 bits internally, so |most-negative| is representable.
- Semantics: quotient truncates toward zero; remainder takes the sign of the dividend; dividend == quotient*divisor + remainder always holds (modulo 2^WIDTH).
- Divide by zero: quotient = all ones, remainder = dividend, dbz=1, V=0.
- Overflow, dividend = -2^(WIDTH-1) and divisor = -1: quotient = -2^(WIDTH-1) (wraps), remainder = 0, V=1. Every other case gives V=0.
- Flags: Z and S are computed from result, not from quotient.
- Outputs quotient, remainder, result, V, Z, S, dbz:
  - update only in FIX;
  - hold their values through the next operation until its done;
  - done is 0 in all other cycles.
- start while busy is ignored: no capture, no restart, no effect on the in-flight operation.
- start in the same cycle done is high: state is FIX→IDLE, so the start is not sampled. A new start is accepted from the cycle after done.
- Reset mid-operation: abort immediately; all outputs return to reset values; no done pulse.

Test Plan:
- 100 / 7, sel_rem=0 → quotient=14, remainder=2, result=14, V=Z=S=dbz=0; done exactly 33 cycles after the start edge, busy high throughout.
- -100 / 7 and 100 / -7, sel_rem=1 → (q,r) = (-14,-2) then (-14,2); result = -2 (S=1) then 2 (S=0).
- 5 / 0 → dbz=1, quotient=0xFFFFFFFF, remainder=5, V=0; done 2 cycles after start; a follow-up 6/3 clears dbz and gives q=2, r=0, Z=0 with sel_rem=0.
- 0x80000000 / -1 → quotient=0x80000000, remainder=0, V=1, S=1; then 3/5 with sel_rem=0 → quotient=0, remainder=3, Z=1, V=0.
- Start 100/7, pulse start with 9/3 at cycle 10 → ignored, result 14 at cycle 33; start asserted on the done cycle → ignored; start on the next cycle → accepted.
- Start 100/7, drop rst_n at cycle 15 → busy=0, outputs zero, no done; after release, 20/4 → quotient=5, done at 33 cycles.
